// File: rtl/wrapper.sv
// AES (FIPS-197) built-in self-test: expands a fixed key, encrypts a fixed
// plaintext, decrypts the result, and reports whether both directions
// reproduce the known-answer vectors for the selected key length.
module wrapper #(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic clk,
    input  logic reset,
    output logic wrapper_out_encrypt,
    output logic wrapper_out_decrypt,
    output logic done
);

    localparam int WORDS = 4 * (Nr + 1);
    localparam int IW    = $clog2(WORDS);
    localparam int RW    = $clog2(Nr + 1);
    localparam bit LEGAL = (Nk == 4) || (Nk == 6) || (Nk == 8);

    localparam logic [127:0] PLAIN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] EXPECT = (Nk == 4) ? 128'h69c4e0d86a7b0430d8cdb78070b4c55a :
                                      (Nk == 6) ? 128'hdda97ca4864cdfe06eaf70a0ec0d7191 :
                                                  128'h8ea2b7ca516745bfeafc49904b496089;

    localparam logic [1:0] KEYEXP = 2'd0;
    localparam logic [1:0] ENC    = 2'd1;
    localparam logic [1:0] DEC    = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    // ---------------- GF(2^8) and round-function helpers ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int k = 0; k < 7; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [15:0] t;
        t = {a, a} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    // Byte k of the state sits at bits [127-8k -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        for (int k = 0; k < 16; k++)
            o[127-8*k -: 8] = inv ? inv_sbox(s[127-8*k -: 8]) : sbox(s[127-8*k -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   m [4];
        logic [7:0]   acc;
        m[0] = inv ? 8'h0e : 8'h02;
        m[1] = inv ? 8'h0b : 8'h03;
        m[2] = inv ? 8'h0d : 8'h01;
        m[3] = inv ? 8'h09 : 8'h01;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(s[127-8*(4*c+j) -: 8], m[(j - r + 4) % 4]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input int j);
        logic [7:0] rc;
        rc = 8'h01;
        for (int k = 2; k <= 10; k++)
            if (k <= j) rc = xtime(rc);
        return rc;
    endfunction

    // Cipher key words are the byte sequence 00,01,02,...
    function automatic logic [31:0] key_word(input int idx);
        return {8'(4*idx), 8'(4*idx+1), 8'(4*idx+2), 8'(4*idx+3)};
    endfunction

    // ---------------- state ----------------
    logic [1:0]    state;
    logic [IW-1:0] i;
    logic [RW-1:0] rnd;
    logic [127:0]  st;
    logic [127:0]  ct;
    logic [31:0]   w_mem [WORDS];

    logic [31:0]   new_word;
    logic [127:0]  round_key;
    logic [127:0]  enc_mid;
    logic [127:0]  dec_mid;

    // Key words below Nk are constants; only generated words live in w_mem.
    function automatic logic [31:0] w_at(input int idx);
        return (idx < Nk) ? key_word(idx) : w_mem[IW'(idx)];
    endfunction

    // Next key-schedule word for index i.
    always_comb begin
        logic [31:0] prev;
        logic [31:0] temp;
        // NOTE: every always_comb output gets a value on every path up front, so no latch is inferred.
        prev = w_at(int'(i) - 1);
        temp = prev;
        if (int'(i) % Nk == 0)
            temp = sub_word({prev[23:0], prev[31:24]}) ^ {rcon(int'(i) / Nk), 24'h000000};
        else if (Nk > 6 && int'(i) % Nk == 4)
            temp = sub_word(prev);
        new_word = w_at(int'(i) - Nk) ^ temp;
    end

    // Round key for the current round: forward order in ENC, reverse in DEC.
    always_comb begin
        int r;
        r = (state == DEC) ? Nr - int'(rnd) : int'(rnd);
        round_key = {w_at(4*r), w_at(4*r+1), w_at(4*r+2), w_at(4*r+3)};
        enc_mid   = shift_rows(sub_bytes(st, 1'b0), 1'b0);
        dec_mid   = sub_bytes(shift_rows(st, 1'b1), 1'b1) ^ round_key;
    end

    // Key-schedule storage, written one word per KEYEXP cycle.
    // NOTE: the word array has no reset; every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (state == KEYEXP && LEGAL)
            w_mem[i] <= new_word;
    end

    // Sequencer: key expansion, encrypt, decrypt, then hold the verdict.
    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= KEYEXP;
            i                   <= IW'(Nk);
            rnd                 <= '0;
            st                  <= '0;
            ct                  <= '0;
            done                <= 1'b0;
            wrapper_out_encrypt <= 1'b0;
            wrapper_out_decrypt <= 1'b0;
        end else begin
            case (state)
                KEYEXP: begin
                    if (!LEGAL) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else if (i == IW'(WORDS - 1)) begin
                        state <= ENC;
                        rnd   <= '0;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                ENC: begin
                    if (rnd == '0) begin
                        st  <= PLAIN ^ round_key;
                        rnd <= rnd + 1'b1;
                    end else if (rnd == RW'(Nr)) begin
                        ct    <= enc_mid ^ round_key;
                        state <= DEC;
                        rnd   <= '0;
                    end else begin
                        st  <= mix_columns(enc_mid, 1'b0) ^ round_key;
                        rnd <= rnd + 1'b1;
                    end
                end
                DEC: begin
                    if (rnd == '0) begin
                        st  <= ct ^ round_key;
                        rnd <= rnd + 1'b1;
                    end else if (rnd == RW'(Nr)) begin
                        state               <= FINISH;
                        done                <= 1'b1;
                        wrapper_out_encrypt <= (ct == EXPECT);
                        wrapper_out_decrypt <= (dec_mid == PLAIN);
                    end else begin
                        st  <= mix_columns(dec_mid, 1'b1);
                        rnd <= rnd + 1'b1;
                    end
                end
                default: ;  // FINISH is terminal until reset
            endcase
        end
    end

endmodule

// File: tb/tb_wrapper.sv
// Self-test bench for wrapper: four instances (Nk = 4, 6, 8 and illegal 5)
// share one clock, each with its own reset; a latency model predicts when
// done must rise and what the verdict outputs must read.
module tb_wrapper;

    localparam int NI = 4;
    localparam int NK_TAB [NI] = '{4, 6, 8, 5};

    logic          clk = 1'b0;
    logic [NI-1:0] rst = '0;
    logic [NI-1:0] enc;
    logic [NI-1:0] dec;
    logic [NI-1:0] dn;

    int total = 0;
    int bad   = 0;
    int since [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        wrapper #(.Nk(NK_TAB[g])) u_dut (
            .clk                 (clk),
            .reset               (rst[g]),
            .wrapper_out_encrypt (enc[g]),
            .wrapper_out_decrypt (dec[g]),
            .done                (dn[g])
        );
    end

    // Reference model: a legal key length finishes after the key-schedule
    // cycles plus one encrypt and one decrypt pass; anything else finishes at once.
    function automatic bit legal(input int nk);
        return (nk == 4) || (nk == 6) || (nk == 8);
    endfunction

    function automatic int lat(input int nk);
        int nr;
        nr = nk + 6;
        return legal(nk) ? (4 * (nr + 1) - nk) + 2 * (nr + 1) : 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance n edges and compare every instance against the model each edge.
    task automatic observe(input int n);
        logic exp_done;
        logic exp_res;
        for (int e = 0; e < n; e++) begin
            step();
            for (int k = 0; k < NI; k++) begin
                if (rst[k]) since[k]++;
                exp_done = rst[k] && (since[k] >= lat(NK_TAB[k]));
                exp_res  = exp_done && legal(NK_TAB[k]);
                total++;
                if (dn[k] !== exp_done) begin
                    bad++;
                    $display("FAIL done nk=%0d edge=%0d got=%b want=%b", NK_TAB[k], since[k], dn[k], exp_done);
                end
                total++;
                if (enc[k] !== exp_res) begin
                    bad++;
                    $display("FAIL encrypt nk=%0d edge=%0d got=%b want=%b", NK_TAB[k], since[k], enc[k], exp_res);
                end
                total++;
                if (dec[k] !== exp_res) begin
                    bad++;
                    $display("FAIL decrypt nk=%0d edge=%0d got=%b want=%b", NK_TAB[k], since[k], dec[k], exp_res);
                end
            end
        end
    endtask

    // Assert reset on the selected instances between edges and require an
    // immediate clear, before any further clock edge.
    task automatic assert_async(input logic [NI-1:0] mask);
        rst = rst & ~mask;
        for (int k = 0; k < NI; k++)
            if (mask[k]) since[k] = 0;
        #1;
        for (int k = 0; k < NI; k++) begin
            if (mask[k]) begin
                total++;
                if ({dn[k], enc[k], dec[k]} !== 3'b000) begin
                    bad++;
                    $display("FAIL async_clear nk=%0d got=%b%b%b want=000", NK_TAB[k], dn[k], enc[k], dec[k]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = '0;
        for (int k = 0; k < NI; k++) since[k] = 0;
        observe(2);
    endtask

    // Full run from release: done edge for each Nk, then 100+ cycles of hold.
    task automatic test_latency();
        rst = '1;
        observe(190);
    endtask

    // Drop reset mid-cycle while every instance shows done=1.
    task automatic test_async();
        #2;
        assert_async('1);
        observe(2);
    endtask

    // Abort mid-operation and require a full-length restart.
    task automatic test_mid_reset();
        int            at;
        int            dur;
        logic [NI-1:0] mask;
        for (int s = 0; s < 4; s++) begin
            rst = '1;
            if (s == 0) begin
                at   = 30;
                dur  = 3;
                mask = '1;
            end else begin
                at   = $urandom_range(1, 85);
                dur  = $urandom_range(1, 4);
                mask = NI'($urandom_range(1, (1 << NI) - 1));
            end
            observe(at);
            assert_async(mask);
            observe(dur);
            rst = '1;
            observe(95);
            test_async();
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) since[k] = 0;
        test_reset();
        test_latency();
        test_async();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
